// File: rtl/c432_resp_checker.sv
// Response checker for the registered c432 wrapper: aligns stim_valid over PIPE_DEPTH cycles, compares
// golden vs dut_out, and accumulates saturating error counters plus a MISR; results visible one cycle after compare, no backpressure.
module c432_resp_checker #(
  parameter int WIDTH      = 7,
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 32,
  parameter logic [WIDTH-1:0] MISR_POLY = 7'h03,
  parameter logic [WIDTH-1:0] MISR_SEED = 7'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             stim_valid,
  input  logic [WIDTH-1:0] golden,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_vec_count,
  output logic [CNT_W-1:0] err_bit_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] signature
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_num_vec;
  logic [CNT_W-1:0]      r_issued;
  logic [CNT_W-1:0]      r_vec;
  logic [CNT_W-1:0]      r_errv;
  logic [CNT_W-1:0]      r_errb;
  logic [CNT_W-1:0]      r_fidx;
  logic                  r_fval;
  logic [WIDTH-1:0]      r_sig;
  logic [PIPE_DEPTH-1:0] r_pipe;

  logic                  w_accept;
  logic                  w_cmp;
  logic                  w_err;
  logic [WIDTH-1:0]      w_diff;
  logic [WIDTH-1:0]      w_sig_nxt;
  logic [CNT_W-1:0]      w_pop;
  logic [CNT_W-1:0]      w_vec_nxt;
  logic [CNT_W-1:0]      w_errv_nxt;
  logic [CNT_W-1:0]      w_errb_nxt;
  logic [CNT_W:0]        w_errb_sum;

  // Strobes past num_vec never enter the delay line, so the pipe drains empty when the run ends.
  assign w_accept = (r_state == S_RUN) && stim_valid && (r_issued < r_num_vec);
  assign w_cmp    = (r_state == S_RUN) && r_pipe[PIPE_DEPTH-1];
  assign w_diff   = golden ^ dut_out;
  assign w_err    = |w_diff;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + CNT_W'(w_diff[i]);
    end
  end

  assign w_vec_nxt  = (r_vec == CNT_MAX) ? r_vec : r_vec + CNT_ONE;
  assign w_errv_nxt = (w_err && r_errv != CNT_MAX) ? r_errv + CNT_ONE : r_errv;
  assign w_errb_sum = {1'b0, r_errb} + {1'b0, w_pop};
  assign w_errb_nxt = w_errb_sum[CNT_W] ? CNT_MAX : w_errb_sum[CNT_W-1:0];
  assign w_sig_nxt  = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? MISR_POLY : '0) ^ dut_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_num_vec <= '0;
      r_issued  <= '0;
      r_vec     <= '0;
      r_errv    <= '0;
      r_errb    <= '0;
      r_fidx    <= '0;
      r_fval    <= 1'b0;
      r_sig     <= MISR_SEED;
      r_pipe    <= '0;
    end else if (start) begin
      // Start takes priority over any compare sample in the same cycle.
      r_state   <= (num_vec == '0) ? S_DONE : S_RUN;
      r_num_vec <= num_vec;
      r_issued  <= '0;
      r_vec     <= '0;
      r_errv    <= '0;
      r_errb    <= '0;
      r_fidx    <= '0;
      r_fval    <= 1'b0;
      r_sig     <= MISR_SEED;
      r_pipe    <= '0;
    end else begin
      r_pipe <= (r_pipe << 1) | PIPE_DEPTH'(w_accept);
      if (w_accept) r_issued <= r_issued + CNT_ONE;
      if (w_cmp) begin
        r_vec  <= w_vec_nxt;
        r_errv <= w_errv_nxt;
        r_errb <= w_errb_nxt;
        r_sig  <= w_sig_nxt;
        if (w_err && !r_fval) begin
          r_fidx <= r_vec;
          r_fval <= 1'b1;
        end
        if (w_vec_nxt == r_num_vec) r_state <= S_DONE;
      end
    end
  end

  assign busy            = (r_state == S_RUN);
  assign done            = (r_state == S_DONE);
  assign vec_count       = r_vec;
  assign err_vec_count   = r_errv;
  assign err_bit_count   = r_errb;
  assign first_err_idx   = r_fidx;
  assign first_err_valid = r_fval;
  assign signature       = r_sig;

endmodule
